// File: rtl/tsu_marker_capture.sv
// Multi-channel marker/phase capture: per-channel FIFOs with seq tags,
// drop accounting and optional phase delta, merged round-robin onto one stream.
module tsu_marker_capture #(
    parameter int N_CH          = 4,
    parameter int PHASE_B_WIDTH = 32,
    parameter int DEPTH         = 4,
    parameter int SEQ_BITS      = 8,
    parameter int DROP_BITS     = 8,
    parameter int CH_BITS       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               in_marker_v,
    input  logic [N_CH*PHASE_B_WIDTH-1:0] in_phase_b,
    input  logic                          delta_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH_BITS-1:0]            out_ch,
    output logic [SEQ_BITS-1:0]           out_seq,
    output logic [PHASE_B_WIDTH-1:0]      out_phase_b,
    output logic [N_CH*DROP_BITS-1:0]     drop_cnt
);

    localparam int PW = PHASE_B_WIDTH;
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [SEQ_BITS-1:0] seq;
        logic [PW-1:0]       val;
    } entry_t;

    entry_t               mem_q  [N_CH][DEPTH];
    logic [AW:0]          wptr_q [N_CH];
    logic [AW:0]          wptr_d [N_CH];
    logic [AW:0]          rptr_q [N_CH];
    logic [AW:0]          rptr_d [N_CH];
    logic [SEQ_BITS-1:0]  seq_q  [N_CH];
    logic [SEQ_BITS-1:0]  seq_d  [N_CH];
    logic [PW-1:0]        last_q [N_CH];
    logic [PW-1:0]        last_d [N_CH];
    logic [DROP_BITS-1:0] drop_q [N_CH];
    logic [DROP_BITS-1:0] drop_d [N_CH];
    logic [N_CH-1:0]      seen_q;
    logic [N_CH-1:0]      seen_d;

    logic [CH_BITS-1:0]   rr_q;
    logic [CH_BITS-1:0]   rr_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [CH_BITS-1:0]   out_ch_q;
    logic [CH_BITS-1:0]   out_ch_d;
    logic [SEQ_BITS-1:0]  out_seq_q;
    logic [SEQ_BITS-1:0]  out_seq_d;
    logic [PW-1:0]        out_phase_q;
    logic [PW-1:0]        out_phase_d;

    logic [N_CH-1:0]      empty;
    logic [N_CH-1:0]      full;
    logic [N_CH-1:0]      push;
    logic [N_CH-1:0]      popv;
    logic [PW-1:0]        cval   [N_CH];
    logic [PW-1:0]        ph     [N_CH];

    logic                 load;
    logic                 found;
    logic [CH_BITS-1:0]   sel;
    int                   idx;
    entry_t               head;

    // FIFO status from wrap-bit pointers
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                       (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
        end
    end

    // Round-robin scan starting after the last winner
    always_comb begin
        load  = !out_valid_q || out_ready;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_q) + k) % N_CH;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                sel   = CH_BITS'(idx);
            end
        end
        head = mem_q[sel][rptr_q[sel][AW-1:0]];
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ph[i]     = in_phase_b[i*PW +: PW];
            popv[i]   = load && found && (sel == CH_BITS'(i));
            push[i]   = in_marker_v[i] && (!full[i] || popv[i]);
            cval[i]   = ph[i];
            seq_d[i]  = seq_q[i];
            last_d[i] = last_q[i];
            seen_d[i] = seen_q[i];
            drop_d[i] = drop_q[i];
            if (delta_mode) begin
                cval[i] = seen_q[i] ? (ph[i] - last_q[i]) : '0;
            end
            if (in_marker_v[i]) begin
                last_d[i] = ph[i];
                seen_d[i] = 1'b1;
                seq_d[i]  = seq_q[i] + 1'b1;
                if (!push[i] && (drop_q[i] != '1)) begin
                    drop_d[i] = drop_q[i] + 1'b1;
                end
            end
            wptr_d[i] = wptr_q[i] + (AW+1)'(push[i]);
            rptr_d[i] = rptr_q[i] + (AW+1)'(popv[i]);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_seq_d   = out_seq_q;
        out_phase_d = out_phase_q;
        rr_d        = rr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_ch_d    = sel;
                out_seq_d   = head.seq;
                out_phase_d = head.val;
                rr_d        = sel;
            end
        end
    end

    // Storage needs no reset: pointers define what is valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!rst && push[i]) begin
                mem_q[i][wptr_q[i][AW-1:0]] <= '{seq: seq_q[i], val: cval[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                seq_q[i]  <= '0;
                last_q[i] <= '0;
                drop_q[i] <= '0;
            end
            seen_q      <= '0;
            rr_q        <= CH_BITS'(N_CH - 1);
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_seq_q   <= '0;
            out_phase_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                seq_q[i]  <= seq_d[i];
                last_q[i] <= last_d[i];
                drop_q[i] <= drop_d[i];
            end
            seen_q      <= seen_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_seq_q   <= out_seq_d;
            out_phase_q <= out_phase_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_seq     = out_seq_q;
    assign out_phase_b = out_phase_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_drop
        assign drop_cnt[g*DROP_BITS +: DROP_BITS] = drop_q[g];
    end

endmodule

// File: tb/tb_tsu_marker_capture.sv
// Directed bench for tsu_marker_capture: latency, arbitration, overflow,
// delta wrap, backpressure, reset, drop saturation and seq wrap.
module tb_tsu_marker_capture;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_marker_v;
    logic [127:0] in_phase_b;
    logic         delta_mode;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_ch;
    logic [7:0]   out_seq;
    logic [31:0]  out_phase_b;
    logic [31:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tsu_marker_capture dut (
        .clk         (clk),
        .rst         (rst),
        .in_marker_v (in_marker_v),
        .in_phase_b  (in_phase_b),
        .delta_mode  (delta_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_seq     (out_seq),
        .out_phase_b (out_phase_b),
        .drop_cnt    (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_marker_v = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_ph(input int ch, input logic [31:0] v);
        in_phase_b[ch*32 +: 32] = v;
    endtask

    task automatic rec(input string tag, input logic [1:0] ch,
                       input logic [7:0] sq, input logic [31:0] p);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".ch"}, 64'(out_ch), 64'(ch));
        check({tag, ".seq"}, 64'(out_seq), 64'(sq));
        check({tag, ".phase"}, 64'(out_phase_b), 64'(p));
    endtask

    initial begin
        in_marker_v = '0;
        in_phase_b  = '0;
        delta_mode  = 1'b0;
        out_ready   = 1'b1;
        do_reset();

        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.ch", 64'(out_ch), 64'd0);
        check("rst.seq", 64'(out_seq), 64'd0);
        check("rst.phase", 64'(out_phase_b), 64'd0);
        check("rst.drop", 64'(drop_cnt), 64'd0);

        // Single marker, two-edge latency
        set_ph(0, 32'h100);
        in_marker_v = 4'b0001;
        step();
        in_marker_v = '0;
        check("lat.t1", 64'(out_valid), 64'd0);
        step();
        rec("single", 2'd0, 8'd0, 32'h100);
        step();
        check("single.done", 64'(out_valid), 64'd0);

        // All channels at once, round-robin from ch0
        do_reset();
        for (int c = 0; c < 4; c++) set_ph(c, 32'(16 * (c + 1)));
        in_marker_v = 4'b1111;
        step();
        in_marker_v = '0;
        step();
        rec("rr0", 2'd0, 8'd0, 32'h10);
        step();
        rec("rr1", 2'd1, 8'd0, 32'h20);
        step();
        rec("rr2", 2'd2, 8'd0, 32'h30);
        step();
        rec("rr3", 2'd3, 8'd0, 32'h40);
        step();
        check("rr.done", 64'(out_valid), 64'd0);

        // Overflow on ch2 under backpressure
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_ph(2, 32'h200 + 32'(k));
            in_marker_v = 4'b0100;
            step();
        end
        in_marker_v = '0;
        rec("ovf.hold", 2'd2, 8'd0, 32'h200);
        check("ovf.drop2", 64'(drop_cnt), 64'h0001_0000);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            rec("ovf.rel", 2'd2, 8'(k), 32'h200 + 32'(k));
        end
        step();
        check("ovf.done", 64'(out_valid), 64'd0);

        // Delta mode across phase wrap on ch1
        do_reset();
        delta_mode = 1'b1;
        set_ph(1, 32'hFFFF_FFF0);
        in_marker_v = 4'b0010;
        step();
        set_ph(1, 32'h0000_0010);
        step();
        in_marker_v = '0;
        delta_mode  = 1'b0;
        rec("delta0", 2'd1, 8'd0, 32'h0);
        step();
        rec("delta1", 2'd1, 8'd1, 32'h20);

        // Backpressure stability, then mid-run reset
        do_reset();
        out_ready = 1'b0;
        set_ph(0, 32'hA);
        set_ph(1, 32'hB);
        set_ph(3, 32'hC);
        in_marker_v = 4'b1011;
        step();
        in_marker_v = '0;
        step();
        for (int k = 0; k < 10; k++) begin
            rec("bp.hold", 2'd0, 8'd0, 32'hA);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            in_marker_v = 4'b1000;
            step();
        end
        in_marker_v = '0;
        check("bp.drop3", 64'(drop_cnt), 64'h0200_0000);
        rst = 1'b1;
        set_ph(0, 32'h99);
        in_marker_v = 4'b0001;
        step();
        rst         = 1'b0;
        in_marker_v = '0;
        check("mrst.valid", 64'(out_valid), 64'd0);
        check("mrst.drop", 64'(drop_cnt), 64'd0);
        out_ready = 1'b1;
        step();
        check("mrst.ignored", 64'(out_valid), 64'd0);
        set_ph(0, 32'h55);
        in_marker_v = 4'b0001;
        step();
        in_marker_v = '0;
        step();
        rec("mrst.next", 2'd0, 8'd0, 32'h55);

        // Drop counter saturation on ch3
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            set_ph(3, 32'(k));
            in_marker_v = 4'b1000;
            step();
        end
        in_marker_v = '0;
        check("sat.drop", 64'(drop_cnt), 64'hFF00_0000);
        rec("sat.hold", 2'd3, 8'd0, 32'd0);

        // Sequence wrap with continuous delivery on ch0
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 258; k++) begin
            set_ph(0, 32'h1000 + 32'(k));
            in_marker_v = 4'b0001;
            step();
            if (k >= 1) rec("wrap", 2'd0, 8'(k - 1), 32'h1000 + 32'(k - 1));
        end
        in_marker_v = '0;
        step();
        rec("wrap.last", 2'd0, 8'd1, 32'h1000 + 32'd257);
        check("wrap.drop", 64'(drop_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
